// File: rtl/axis_pkt_gen.sv
// AXI4-Stream traffic source: a programmable header beat followed by sequence-numbered
// payload beats, with backpressure, inter-packet gap and packet/byte statistics.
module axis_pkt_gen #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned LEN_WIDTH          = 16,
  parameter int unsigned GAP_WIDTH          = 8
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              start,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      cfg_hdr,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     cfg_tuser,
  input  logic [LEN_WIDTH-1:0]              cfg_pkt_beats,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    cfg_last_keep,
  input  logic [31:0]                       cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0]              cfg_gap,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              done,
  output logic [63:0]                       stat_pkts,
  output logic [63:0]                       stat_bytes
);

  localparam int unsigned DW  = C_AXIS_DATA_WIDTH;
  localparam int unsigned KW  = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned TUW = C_AXIS_TUSER_WIDTH;
  localparam int unsigned LW  = LEN_WIDTH;
  localparam int unsigned GW  = GAP_WIDTH;

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StGap, StDone} state_e;

  state_e          r_state, w_state_nxt;

  logic [DW-1:0]   r_tdata, w_tdata_nxt;
  logic [KW-1:0]   r_tkeep, w_tkeep_nxt;
  logic [TUW-1:0]  r_tuser, w_tuser_nxt;
  logic            r_tvalid, w_tvalid_nxt;
  logic            r_tlast, w_tlast_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;

  // Configuration captured at every header entry
  logic [LW-1:0]   r_beats, w_beats_nxt;
  logic [KW-1:0]   r_keep, w_keep_nxt;
  logic [31:0]     r_num, w_num_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;

  logic [LW-1:0]   r_idx, w_idx_nxt;
  logic [63:0]     r_seq, w_seq_nxt;
  logic [31:0]     r_pkt_cnt, w_pkt_cnt_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [63:0]     r_stat_pkts, w_stat_pkts_nxt;
  logic [63:0]     r_stat_bytes, w_stat_bytes_nxt;

  logic            w_hs;
  logic            w_load_hdr;
  logic [LW-1:0]   w_in_beats;
  logic [KW-1:0]   w_in_keep;
  logic [LW-1:0]   w_idx_inc;
  logic            w_pay_last;
  logic [63:0]     w_pay_sum;
  logic [DW-1:0]   w_pay_data;
  logic [31:0]     w_pkt_cnt_inc;
  logic [63:0]     w_pop;

  assign w_hs          = r_tvalid & m_axis_tready;
  assign w_in_beats    = (cfg_pkt_beats == '0) ? LW'(1) : cfg_pkt_beats;
  assign w_in_keep     = (cfg_last_keep == '0) ? '1 : cfg_last_keep;
  assign w_idx_inc     = r_idx + LW'(1);
  assign w_pay_last    = (w_idx_inc == r_beats - LW'(1));
  assign w_pay_sum     = r_seq + 64'(w_idx_inc);
  assign w_pay_data    = DW'(w_pay_sum);
  assign w_pkt_cnt_inc = r_pkt_cnt + 32'd1;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KW; i++) begin
      w_pop = w_pop + 64'(r_tkeep[i]);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tdata_nxt      = r_tdata;
    w_tkeep_nxt      = r_tkeep;
    w_tuser_nxt      = r_tuser;
    w_tvalid_nxt     = r_tvalid;
    w_tlast_nxt      = r_tlast;
    w_beats_nxt      = r_beats;
    w_keep_nxt       = r_keep;
    w_num_nxt        = r_num;
    w_gap_nxt        = r_gap;
    w_idx_nxt        = r_idx;
    w_seq_nxt        = r_seq;
    w_pkt_cnt_nxt    = r_pkt_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_stat_pkts_nxt  = r_stat_pkts;
    w_stat_bytes_nxt = w_hs ? (r_stat_bytes + w_pop) : r_stat_bytes;
    w_load_hdr       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) w_load_hdr = 1'b1;
      end
      StHdr, StPay: begin
        // Beat registers only move on a handshake, keeping the AXI hold rule
        if (w_hs) begin
          if (r_tlast) begin
            w_tvalid_nxt    = 1'b0;
            w_tlast_nxt     = 1'b0;
            w_seq_nxt       = r_seq + 64'd1;
            w_stat_pkts_nxt = r_stat_pkts + 64'd1;
            w_pkt_cnt_nxt   = w_pkt_cnt_inc;
            if ((r_num != '0) && (w_pkt_cnt_inc == r_num)) begin
              w_state_nxt = StDone;
            end else if (!start) begin
              w_state_nxt = StIdle;
            end else if (r_gap != '0) begin
              w_state_nxt   = StGap;
              w_gap_cnt_nxt = r_gap;
            end else begin
              w_load_hdr = 1'b1;
            end
          end else begin
            w_state_nxt = StPay;
            w_idx_nxt   = w_idx_inc;
            w_tdata_nxt = w_pay_data;
            w_tuser_nxt = '0;
            w_tlast_nxt = w_pay_last;
            w_tkeep_nxt = w_pay_last ? r_keep : '1;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt <= GW'(1)) begin
          if (start) w_load_hdr = 1'b1;
          else       w_state_nxt = StIdle;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GW'(1);
        end
      end
      StDone: begin
        if (!start) begin
          w_state_nxt   = StIdle;
          w_pkt_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_load_hdr) begin
      w_state_nxt  = StHdr;
      w_beats_nxt  = w_in_beats;
      w_keep_nxt   = w_in_keep;
      w_num_nxt    = cfg_num_pkts;
      w_gap_nxt    = cfg_gap;
      w_idx_nxt    = '0;
      w_tdata_nxt  = cfg_hdr;
      w_tuser_nxt  = cfg_tuser;
      w_tvalid_nxt = 1'b1;
      w_tlast_nxt  = (w_in_beats == LW'(1));
      w_tkeep_nxt  = (w_in_beats == LW'(1)) ? w_in_keep : '1;
    end

    w_busy_nxt = (w_state_nxt == StHdr) || (w_state_nxt == StPay) || (w_state_nxt == StGap);
    w_done_nxt = (w_state_nxt == StDone);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state      <= StIdle;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tuser      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_beats      <= LW'(1);
      r_keep       <= '1;
      r_num        <= '0;
      r_gap        <= '0;
      r_idx        <= '0;
      r_seq        <= 64'd1;
      r_pkt_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_stat_pkts  <= '0;
      r_stat_bytes <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tdata      <= w_tdata_nxt;
      r_tkeep      <= w_tkeep_nxt;
      r_tuser      <= w_tuser_nxt;
      r_tvalid     <= w_tvalid_nxt;
      r_tlast      <= w_tlast_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_beats      <= w_beats_nxt;
      r_keep       <= w_keep_nxt;
      r_num        <= w_num_nxt;
      r_gap        <= w_gap_nxt;
      r_idx        <= w_idx_nxt;
      r_seq        <= w_seq_nxt;
      r_pkt_cnt    <= w_pkt_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_stat_pkts  <= w_stat_pkts_nxt;
      r_stat_bytes <= w_stat_bytes_nxt;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign stat_pkts     = r_stat_pkts;
  assign stat_bytes    = r_stat_bytes;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: beat content, gaps, backpressure, early stop and reset.
module tb_axis_pkt_gen;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int TUW = 128;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic           start = 1'b0;
  logic [DW-1:0]  cfg_hdr = '0;
  logic [TUW-1:0] cfg_tuser = '0;
  logic [15:0]    cfg_pkt_beats = '0;
  logic [KW-1:0]  cfg_last_keep = '0;
  logic [31:0]    cfg_num_pkts = '0;
  logic [7:0]     cfg_gap = '0;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic [TUW-1:0] m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic           busy;
  logic           done;
  logic [63:0]    stat_pkts;
  logic [63:0]    stat_bytes;

  axis_pkt_gen dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .start         (start),
    .cfg_hdr       (cfg_hdr),
    .cfg_tuser     (cfg_tuser),
    .cfg_pkt_beats (cfg_pkt_beats),
    .cfg_last_keep (cfg_last_keep),
    .cfg_num_pkts  (cfg_num_pkts),
    .cfg_gap       (cfg_gap),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .stat_pkts     (stat_pkts),
    .stat_bytes    (stat_bytes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]  q_data[$];
  logic [KW-1:0]  q_keep[$];
  logic [TUW-1:0] q_user[$];
  logic           q_last[$];
  int             q_cyc[$];

  logic [DW-1:0]  hdr_a = {16{32'h1234_ABCD}};
  logic [TUW-1:0] user_a = {4{32'hFEED_0001}};
  logic [KW-1:0]  ones = '1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    start = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Records handshaken beats; checks AXI hold while stalled; optionally drops start.
  task automatic capture(input int limit, input bit alt, input int drop_at);
    bit             hold = 1'b0;
    logic [DW-1:0]  pd = '0;
    logic [KW-1:0]  pk = '0;
    logic [TUW-1:0] pu = '0;
    logic           pl = 1'b0;
    int             got = 0;
    q_data.delete(); q_keep.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
    for (int cyc = 0; cyc < 300 && got < limit; cyc++) begin
      m_axis_tready = alt ? (cyc % 2 == 0) : 1'b1;
      if (hold) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tkeep !== pk ||
            m_axis_tuser !== pu || m_axis_tlast !== pl) begin
          n_errors++;
          $display("FAIL stable cyc%0d: valid=%0b data=%0h keep=%0h last=%0b want data=%0h keep=%0h last=%0b",
                   cyc, m_axis_tvalid, m_axis_tdata[63:0], m_axis_tkeep, m_axis_tlast,
                   pd[63:0], pk, pl);
        end
      end
      hold = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; pk = m_axis_tkeep; pu = m_axis_tuser; pl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_keep.push_back(m_axis_tkeep);
        q_user.push_back(m_axis_tuser);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(cyc);
        got++;
        if (got == drop_at) start = 1'b0;
      end
      tick();
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
        m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
      n_errors++;
      $display("FAIL reset_stream: valid=%0b last=%0b data=%0h keep=%0h want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata[63:0], m_axis_tkeep);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stat_pkts !== 64'd0 || stat_bytes !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_status: busy=%0b done=%0b pkts=%0d bytes=%0d want 0 0 0 0",
               busy, done, stat_pkts, stat_bytes);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    do_reset();
    cfg_hdr = hdr_a; cfg_tuser = user_a; cfg_pkt_beats = 16'd1; cfg_last_keep = ones;
    cfg_num_pkts = 32'd3; cfg_gap = 8'd0;
    start = 1'b1;
    capture(3, 1'b0, 0);
    n_checks++;
    if (q_data.size() != 3) begin
      n_errors++;
      $display("FAIL single_count: got %0d beats want 3", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 3; i++) begin
      n_checks++;
      if (q_data[i] !== hdr_a || q_last[i] !== 1'b1 || q_keep[i] !== ones ||
          q_user[i] !== user_a || q_cyc[i] != i + 1) begin
        n_errors++;
        $display("FAIL single_beat%0d: data=%0h last=%0b keep=%0h cyc=%0d want data=%0h last=1 keep=%0h cyc=%0d",
                 i, q_data[i][63:0], q_last[i], q_keep[i], q_cyc[i], hdr_a[63:0], ones, i + 1);
      end
    end
    n_checks++;
    if (stat_pkts !== 64'd3 || stat_bytes !== 64'd192 || done !== 1'b1) begin
      n_errors++;
      $display("FAIL single_stats: pkts=%0d bytes=%0d done=%0b want 3 192 1",
               stat_pkts, stat_bytes, done);
    end
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL done_exit: done=%0b busy=%0b valid=%0b want 0 0 0", done, busy, m_axis_tvalid);
    end
  endtask

  task automatic test_gap(input bit alt);
    logic [DW-1:0]  ed[8];
    logic [KW-1:0]  ek[8];
    logic [TUW-1:0] eu[8];
    logic           el[8];
    do_reset();
    cfg_hdr = hdr_a; cfg_tuser = user_a; cfg_pkt_beats = 16'd4; cfg_last_keep = 64'h3F;
    cfg_num_pkts = 32'd2; cfg_gap = 8'd2;
    ed[0] = hdr_a;    ed[1] = 512'd2; ed[2] = 512'd3; ed[3] = 512'd4;
    ed[4] = hdr_a;    ed[5] = 512'd3; ed[6] = 512'd4; ed[7] = 512'd5;
    for (int i = 0; i < 8; i++) begin
      ek[i] = (i % 4 == 3) ? 64'h3F : ones;
      el[i] = (i % 4 == 3);
      eu[i] = (i % 4 == 0) ? user_a : '0;
    end
    start = 1'b1;
    capture(8, alt, 0);
    n_checks++;
    if (q_data.size() != 8) begin
      n_errors++;
      $display("FAIL gap_count alt=%0b: got %0d beats want 8", alt, q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      n_checks++;
      if (q_data[i] !== ed[i] || q_keep[i] !== ek[i] || q_last[i] !== el[i] ||
          q_user[i] !== eu[i]) begin
        n_errors++;
        $display("FAIL gap_beat%0d alt=%0b: data=%0h keep=%0h last=%0b user=%0h want data=%0h keep=%0h last=%0b user=%0h",
                 i, alt, q_data[i][63:0], q_keep[i], q_last[i], q_user[i],
                 ed[i][63:0], ek[i], el[i], eu[i]);
      end
    end
    if (!alt && q_cyc.size() == 8) begin
      n_checks++;
      if (q_cyc[4] - q_cyc[3] != 3) begin
        n_errors++;
        $display("FAIL gap_idle: got %0d idle cycles want 2", q_cyc[4] - q_cyc[3] - 1);
      end
    end
    n_checks++;
    if (stat_pkts !== 64'd2 || stat_bytes !== 64'd396 || done !== 1'b1) begin
      n_errors++;
      $display("FAIL gap_stats alt=%0b: pkts=%0d bytes=%0d done=%0b want 2 396 1",
               alt, stat_pkts, stat_bytes, done);
    end
  endtask

  task automatic test_stop_mid_packet();
    do_reset();
    cfg_hdr = hdr_a; cfg_tuser = user_a; cfg_pkt_beats = 16'd8; cfg_last_keep = ones;
    cfg_num_pkts = 32'd0; cfg_gap = 8'd0;
    start = 1'b1;
    capture(8, 1'b0, 3);
    n_checks++;
    if (q_data.size() != 8) begin
      n_errors++;
      $display("FAIL stop_count: got %0d beats want 8", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      n_checks++;
      if (q_data[i] !== ((i == 0) ? hdr_a : DW'(i + 1)) || q_last[i] !== (i == 7)) begin
        n_errors++;
        $display("FAIL stop_beat%0d: data=%0h last=%0b want data=%0h last=%0b",
                 i, q_data[i][63:0], q_last[i], (i == 0) ? hdr_a[63:0] : 64'(i + 1), (i == 7));
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || stat_pkts !== 64'd1 ||
        stat_bytes !== 64'd512) begin
      n_errors++;
      $display("FAIL stop_after: busy=%0b valid=%0b pkts=%0d bytes=%0d want 0 0 1 512",
               busy, m_axis_tvalid, stat_pkts, stat_bytes);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    cfg_hdr = hdr_a; cfg_tuser = user_a; cfg_pkt_beats = 16'd4; cfg_last_keep = ones;
    cfg_num_pkts = 32'd0; cfg_gap = 8'd0;
    start = 1'b1;
    capture(2, 1'b0, 0);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || stat_bytes !== 64'd128) begin
      n_errors++;
      $display("FAIL pre_reset: valid=%0b bytes=%0d want 1 128", m_axis_tvalid, stat_bytes);
    end
    aresetn = 1'b0;
    tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || stat_pkts !== 64'd0 ||
        stat_bytes !== 64'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: valid=%0b last=%0b pkts=%0d bytes=%0d busy=%0b want all 0",
               m_axis_tvalid, m_axis_tlast, stat_pkts, stat_bytes, busy);
    end
    aresetn = 1'b1;
    capture(4, 1'b0, 0);
    n_checks++;
    if (q_data.size() != 4) begin
      n_errors++;
      $display("FAIL restart_count: got %0d beats want 4", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      n_checks++;
      if (q_data[i] !== ((i == 0) ? hdr_a : DW'(i + 1)) || q_last[i] !== (i == 3)) begin
        n_errors++;
        $display("FAIL restart_beat%0d: data=%0h last=%0b want data=%0h last=%0b",
                 i, q_data[i][63:0], q_last[i], (i == 0) ? hdr_a[63:0] : 64'(i + 1), (i == 3));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_zero_cfg();
    do_reset();
    cfg_hdr = ~hdr_a; cfg_tuser = user_a; cfg_pkt_beats = 16'd0; cfg_last_keep = '0;
    cfg_num_pkts = 32'd2; cfg_gap = 8'd0;
    start = 1'b1;
    capture(2, 1'b0, 0);
    n_checks++;
    if (q_data.size() != 2) begin
      n_errors++;
      $display("FAIL zero_count: got %0d beats want 2", q_data.size());
    end
    for (int i = 0; i < q_data.size() && i < 2; i++) begin
      n_checks++;
      if (q_data[i] !== ~hdr_a || q_keep[i] !== ones || q_last[i] !== 1'b1) begin
        n_errors++;
        $display("FAIL zero_beat%0d: data=%0h keep=%0h last=%0b want data=%0h keep=%0h last=1",
                 i, q_data[i][63:0], q_keep[i], q_last[i], ~hdr_a[63:0], ones);
      end
    end
    n_checks++;
    if (stat_bytes !== 64'd128 || done !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_stats: bytes=%0d done=%0b want 128 1", stat_bytes, done);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_gap(1'b0);
    test_gap(1'b1);
    test_stop_mid_packet();
    test_reset_mid_packet();
    test_zero_cfg();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
